// File: rtl/sw_pkg.sv
// -----------------------------------------------------------------------------
// sw_pkg
// Shared definitions for the stopwatch mode controller: FSM state encoding
// (also driven onto the debug/LED state port) and default timing constants.
// -----------------------------------------------------------------------------
package sw_pkg;

    // 10 ms of debounce at 100 MHz.
    localparam int DB_CYCLES_DEF  = 1000000;
    // clr_on pulse width; at least 2 so the counter's 2-FF edge detector sees it.
    localparam int CLR_CYCLES_DEF = 4;

    // Codes 5-7 are unused and recover to ST_IDLE.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_LAP   = 3'd2,
        ST_STOP  = 3'd3,
        ST_CLEAR = 3'd4
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Synchronizes and debounces one raw pushbutton and emits a single-cycle
// press pulse on each accepted 0->1 transition. Releases produce no pulse.
//
// Ports:
//   rst    in   asynchronous active-low reset
//   clk    in   system clock
//   btn    in   raw, asynchronous, bouncing button level (active high)
//   press  out  registered 1-cycle pulse when the accepted level rises
// -----------------------------------------------------------------------------
module btn_debounce
    import sw_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic rst,
    input  logic clk,
    input  logic btn,
    output logic press
);

    localparam int            CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [1:0]    sync_q;    // [0] first stage, [1] safe to use
    logic          stable;    // accepted level
    logic          stable_d;  // accepted level one cycle ago, for edge detect
    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, e.g. the two synchronizer stages shift cleanly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q   <= '0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], btn};
            stable_d <= stable;
            press    <= stable & ~stable_d;

            // Any sample matching the accepted level restarts the count, so
            // only an unbroken run of DB_CYCLES differing samples is accepted.
            if (sync_q[1] != stable) begin
                if (cnt == CNT_MAX) begin
                    stable <= sync_q[1];
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/sw_mode_ctrl.sv
// -----------------------------------------------------------------------------
// sw_mode_ctrl
// Front-end mode controller for the stopwatch counter/prescaler. Debounces the
// run and clear pushbuttons and sequences IDLE/RUN/LAP/STOP/CLEAR.
//
// Ports:
//   rst       in   asynchronous active-low reset
//   clk       in   100 MHz system clock
//   btn_run   in   raw start/stop button
//   btn_clr   in   raw lap/clear button
//   run_md    out  counter run enable (RUN or LAP)
//   clr_on    out  counter clear request, high for CLR_CYCLES in CLEAR
//   lap_hold  out  display freeze (LAP)
//   state     out  current FSM state code
// -----------------------------------------------------------------------------
module sw_mode_ctrl
    import sw_pkg::*;
#(
    parameter int DB_CYCLES  = DB_CYCLES_DEF,
    parameter int CLR_CYCLES = CLR_CYCLES_DEF
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       btn_run,
    input  logic       btn_clr,
    output logic       run_md,
    output logic       clr_on,
    output logic       lap_hold,
    output logic [2:0] state
);

    localparam int             CCW      = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CCW-1:0] CLR_LOAD = CCW'(CLR_CYCLES - 1);

    logic           run_ev;
    logic           clr_ev;
    state_t         state_q;
    state_t         state_nx;
    logic [CCW-1:0] clr_cnt;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
        .rst   (rst),
        .clk   (clk),
        .btn   (btn_run),
        .press (run_ev)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .rst   (rst),
        .clk   (clk),
        .btn   (btn_clr),
        .press (clr_ev)
    );

    // Next-state logic. run_ev is tested first in every state so it wins
    // over a simultaneous clr_ev, which is then simply dropped.
    // NOTE: state_nx gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (run_ev)      state_nx = ST_RUN;
                else if (clr_ev) state_nx = ST_CLEAR;
            end
            ST_RUN: begin
                if (run_ev)      state_nx = ST_STOP;
                else if (clr_ev) state_nx = ST_LAP;
            end
            ST_LAP: begin
                if (run_ev)      state_nx = ST_STOP;
                else if (clr_ev) state_nx = ST_RUN;
            end
            ST_STOP: begin
                if (run_ev)      state_nx = ST_RUN;
                else if (clr_ev) state_nx = ST_CLEAR;
            end
            ST_CLEAR: begin
                // Button events are ignored until the clear pulse completes.
                if (clr_cnt == '0) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State, clear down-counter and outputs. Outputs decode state_nx so the
    // registered outputs change on the same edge as the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            clr_cnt  <= '0;
            run_md   <= 1'b0;
            clr_on   <= 1'b0;
            lap_hold <= 1'b0;
        end else begin
            state_q <= state_nx;

            // Loaded with CLR_CYCLES-1 on entry; leaving when it reads zero
            // gives exactly CLR_CYCLES cycles in CLEAR.
            if (state_nx == ST_CLEAR && state_q != ST_CLEAR) begin
                clr_cnt <= CLR_LOAD;
            end else if (state_q == ST_CLEAR && clr_cnt != '0) begin
                clr_cnt <= clr_cnt - CCW'(1);
            end

            // CLEAR never decodes run_md, so run_md and clr_on are exclusive.
            run_md   <= (state_nx == ST_RUN) || (state_nx == ST_LAP);
            lap_hold <= (state_nx == ST_LAP);
            clr_on   <= (state_nx == ST_CLEAR);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_sw_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sw_mode_ctrl
// Directed bench for sw_mode_ctrl with DB_CYCLES=4, CLR_CYCLES=3, so a steady
// press changes the outputs exactly 8 edges after its first sampled high.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_sw_mode_ctrl;

    logic       rst;
    logic       clk;
    logic       btn_run;
    logic       btn_clr;
    logic       run_md;
    logic       clr_on;
    logic       lap_hold;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    sw_mode_ctrl #(.DB_CYCLES(4), .CLR_CYCLES(3)) dut (
        .rst      (rst),
        .clk      (clk),
        .btn_run  (btn_run),
        .btn_clr  (btn_clr),
        .run_md   (run_md),
        .clr_on   (clr_on),
        .lap_hold (lap_hold),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Hold a button for `hold` edges, release it, and let the release settle.
    task automatic press(input bit is_run, input int hold);
        if (is_run) btn_run = 1'b1; else btn_clr = 1'b1;
        tick(hold);
        btn_run = 1'b0;
        btn_clr = 1'b0;
        tick(10);
    endtask

    initial begin
        rst     = 1'b0;
        btn_run = 1'b0;
        btn_clr = 1'b0;

        // ---- reset state ----
        tick(3);
        check("rst_state",    state,    3'd0);
        check("rst_run_md",   run_md,   1'b0);
        check("rst_clr_on",   clr_on,   1'b0);
        check("rst_lap_hold", lap_hold, 1'b0);
        rst = 1'b1;
        tick(3);
        check("idle_quiet", state, 3'd0);

        // ---- run press held 20 edges: one event, 8-edge latency ----
        btn_run = 1'b1;
        tick(7);
        check("run_lat7_md", run_md, 1'b0);
        check("run_lat7_st", state,  3'd0);
        tick(1);
        check("run_lat8_md", run_md, 1'b1);
        check("run_lat8_st", state,  3'd1);
        tick(12);
        btn_run = 1'b0;
        tick(10);
        check("run_hold_one_ev", state, 3'd1);

        // ---- lap sequence ----
        press(1'b0, 10);
        check("lap1_st",   state,    3'd2);
        check("lap1_hold", lap_hold, 1'b1);
        check("lap1_md",   run_md,   1'b1);
        press(1'b0, 10);
        check("unlap_st",   state,    3'd1);
        check("unlap_hold", lap_hold, 1'b0);
        press(1'b0, 10);
        check("lap2_st", state, 3'd2);
        press(1'b1, 10);
        check("lap_stop_st",   state,    3'd3);
        check("lap_stop_md",   run_md,   1'b0);
        check("lap_stop_hold", lap_hold, 1'b0);

        // ---- clear from STOP, run press lands mid-CLEAR ----
        btn_clr = 1'b1;
        tick(1);
        btn_run = 1'b1;   // its event arrives on clr edge 9, inside CLEAR
        tick(6);
        check("clr_e7_on", clr_on, 1'b0);
        check("clr_e7_st", state,  3'd3);
        tick(1);
        check("clr_e8_on", clr_on, 1'b1);
        check("clr_e8_md", run_md, 1'b0);
        check("clr_e8_st", state,  3'd4);
        tick(1);
        check("clr_e9_on", clr_on, 1'b1);
        check("clr_e9_md", run_md, 1'b0);
        tick(1);
        check("clr_e10_on", clr_on, 1'b1);
        check("clr_e10_st", state,  3'd4);
        tick(1);
        check("clr_e11_on", clr_on, 1'b0);
        check("clr_e11_st", state,  3'd0);
        tick(9);
        btn_run = 1'b0;
        btn_clr = 1'b0;
        tick(10);
        check("clr_run_dropped", state, 3'd0);
        check("clr_end_md",      run_md, 1'b0);

        // ---- bounce 1,0,1,0,1 at 2-edge intervals then hold ----
        btn_run = 1'b1; tick(2);
        btn_run = 1'b0; tick(2);
        btn_run = 1'b1; tick(2);
        btn_run = 1'b0; tick(2);
        btn_run = 1'b1;
        tick(7);
        check("bounce_e7_st", state, 3'd0);
        tick(1);
        check("bounce_e8_st", state,  3'd1);
        check("bounce_e8_md", run_md, 1'b1);
        tick(10);
        btn_run = 1'b0;
        tick(10);
        check("bounce_one_ev", state, 3'd1);

        // ---- simultaneous run+clr in RUN: run wins ----
        btn_run = 1'b1;
        btn_clr = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            check("simul_lap_hold", lap_hold, 1'b0);
            if (i == 7) check("simul_e7_st", state, 3'd1);
            if (i == 8) check("simul_e8_st", state, 3'd3);
        end
        btn_run = 1'b0;
        btn_clr = 1'b0;
        tick(10);
        check("simul_end_st", state,  3'd3);
        check("simul_end_md", run_md, 1'b0);

        // ---- reset mid-RUN and mid-debounce ----
        press(1'b1, 10);
        check("rerun_st", state, 3'd1);
        btn_run = 1'b1;
        tick(3);
        rst = 1'b0;
        #1;
        check("async_rst_st",   state,    3'd0);
        check("async_rst_md",   run_md,   1'b0);
        check("async_rst_hold", lap_hold, 1'b0);
        check("async_rst_clr",  clr_on,   1'b0);
        btn_run = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(20);
        check("post_rst_no_ev", state, 3'd0);

        // ---- press held across reset release needs a fresh debounce ----
        btn_run = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(7);
        check("fresh_db_e7", state, 3'd0);
        tick(1);
        check("fresh_db_e8", state, 3'd1);
        btn_run = 1'b0;
        tick(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
